// File: rtl/rv32i_controller.sv
// RV32I main decoder: maps an instruction word to the packed 16-bit control word
// {EX_OP, EXEA, EXEB, LDEXT, MEMR, MEMW, REGW, M2R, BRA, JMP}, optionally registered.
module rv32i_controller #(
  parameter bit REGISTERED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [15:0] ctrlSignals
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  // ALU op from funct3; instr[30] only matters for ADD/SUB (register form) and SRL/SRA.
  function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic f7b5,
                                        input logic is_imm);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = (f7b5 && !is_imm) ? 4'd1 : 4'd0;
      3'b001:  op = 4'd2;
      3'b010:  op = 4'd3;
      3'b011:  op = 4'd4;
      3'b100:  op = 4'd5;
      3'b101:  op = f7b5 ? 4'd7 : 4'd6;
      3'b110:  op = 4'd8;
      3'b111:  op = 4'd9;
      default: op = 4'd0;
    endcase
    return op;
  endfunction

  function automatic logic [15:0] decode(input logic [6:0] opcode, input logic [2:0] funct3,
                                         input logic f7b5);
    logic [3:0] ex_op;
    logic [1:0] exea;
    logic       exeb;
    logic [2:0] ldext;
    logic       memr, memw, regw, m2r, bra, jmp;
    ex_op = 4'd0;
    exea  = SRC_A_RS1;
    exeb  = 1'b0;
    ldext = 3'b000;
    memr  = 1'b0;
    memw  = 1'b0;
    regw  = 1'b0;
    m2r   = 1'b0;
    bra   = 1'b0;
    jmp   = 1'b0;
    case (opcode)
      OPC_OP: begin
        ex_op = alu_op(funct3, f7b5, 1'b0);
        regw  = 1'b1;
      end
      OPC_OP_IMM: begin
        ex_op = alu_op(funct3, f7b5, 1'b1);
        exeb  = 1'b1;
        regw  = 1'b1;
      end
      OPC_LOAD: begin
        exeb  = 1'b1;
        ldext = funct3;
        memr  = 1'b1;
        regw  = 1'b1;
        m2r   = 1'b1;
      end
      OPC_STORE: begin
        exeb  = 1'b1;
        ldext = funct3;
        memw  = 1'b1;
      end
      OPC_BRANCH: begin
        exea = SRC_A_PC;
        exeb = 1'b1;
        bra  = 1'b1;
      end
      OPC_JAL: begin
        exea = SRC_A_PC;
        exeb = 1'b1;
        regw = 1'b1;
        jmp  = 1'b1;
      end
      OPC_JALR: begin
        exeb = 1'b1;
        regw = 1'b1;
        jmp  = 1'b1;
      end
      OPC_LUI: begin
        exea = SRC_A_ZERO;
        exeb = 1'b1;
        regw = 1'b1;
      end
      OPC_AUIPC: begin
        exea = SRC_A_PC;
        exeb = 1'b1;
        regw = 1'b1;
      end
      // FENCE, SYSTEM and illegal opcodes all decode to an all-zero word.
      default: begin
        ex_op = 4'd0;
      end
    endcase
    return {ex_op, exea, exeb, ldext, memr, memw, regw, m2r, bra, jmp};
  endfunction

  logic [15:0] w_ctrl;
  logic        w_unused_instr;

  assign w_ctrl         = decode(instr[6:0], instr[14:12], instr[30]);
  assign w_unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  if (REGISTERED) begin : g_reg
    logic [15:0] r_ctrl;

    // Output register; reset clears the word for the following cycle only.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_ctrl <= 16'h0000;
      end else begin
        r_ctrl <= w_ctrl;
      end
    end

    assign ctrlSignals = r_ctrl;
  end else begin : g_comb
    logic w_unused_clk_rst;

    assign w_unused_clk_rst = clk ^ rst;
    assign ctrlSignals      = w_ctrl;
  end

endmodule

// File: tb/tb_rv32i_controller.sv
// Self-checking bench: a combinational and a registered decoder share instr/rst;
// expected words are queued at drive time and popped when each DUT's output is due.
module tb_rv32i_controller;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [15:0] ctrl_c;
  logic [15:0] ctrl_r;

  logic [15:0] q_c[$];
  logic [15:0] q_r[$];
  int          n_tests;
  int          n_fail;

  rv32i_controller #(.REGISTERED(1'b0)) dut_c (
    .clk(clk), .rst(rst), .instr(instr), .ctrlSignals(ctrl_c)
  );

  rv32i_controller #(.REGISTERED(1'b1)) dut_r (
    .clk(clk), .rst(rst), .instr(instr), .ctrlSignals(ctrl_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden encodings (rd=x1, rs1=x2, rs2=x3 where applicable) and control words.
  localparam int NG = 40;
  localparam logic [31:0] G_INS [NG] = '{
    32'h003100B3, 32'h403100B3, 32'h003110B3, 32'h003120B3, 32'h003130B3,
    32'h003140B3, 32'h003150B3, 32'h403150B3, 32'h003160B3, 32'h003170B3,
    32'h00110093, 32'h00112093, 32'h00113093, 32'h00114093, 32'h00116093,
    32'h00117093, 32'h00111093, 32'h00115093, 32'h40115093,
    32'h00010083, 32'h00011083, 32'h00012083, 32'h00014083, 32'h00015083,
    32'h00110023, 32'h00111023, 32'h00112023,
    32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063, 32'h00006063, 32'h00007063,
    32'h000000EF, 32'h000100E7, 32'h000010B7, 32'h00001097,
    32'h0FF0000F, 32'h00000073, 32'h00100073
  };
  localparam logic [15:0] G_EXP [NG] = '{
    16'h0008, 16'h1008, 16'h2008, 16'h3008, 16'h4008,
    16'h5008, 16'h6008, 16'h7008, 16'h8008, 16'h9008,
    16'h0208, 16'h3208, 16'h4208, 16'h5208, 16'h8208,
    16'h9208, 16'h2208, 16'h6208, 16'h7208,
    16'h022C, 16'h026C, 16'h02AC, 16'h032C, 16'h036C,
    16'h0210, 16'h0250, 16'h0290,
    16'h0602, 16'h0602, 16'h0602, 16'h0602, 16'h0602, 16'h0602,
    16'h0609, 16'h0209, 16'h0A08, 16'h0608,
    16'h0000, 16'h0000, 16'h0000
  };

  task automatic drive(input logic [31:0] ins, input logic rs, input logic [15:0] exp);
    @(negedge clk);
    instr = ins;
    rst   = rs;
    q_c.push_back(exp);
    q_r.push_back(rs ? 16'h0000 : exp);
  endtask

  task automatic test_reset();
    logic [15:0] e;
    for (int k = 0; k < 2; k++) begin
      drive(32'h003100B3, 1'b1, 16'h0008);
      #1;
      e = q_c.pop_front();
      n_tests++;
      if (ctrl_c !== e) begin
        n_fail++;
        $display("FAIL reset_comb_%0d: got %h expected %h", k, ctrl_c, e);
      end
      @(posedge clk);
      #1;
      e = q_r.pop_front();
      n_tests++;
      if (ctrl_r !== e) begin
        n_fail++;
        $display("FAIL reset_reg_%0d: got %h expected %h", k, ctrl_r, e);
      end
    end
    // Unknown reset must not disturb the combinational build.
    @(negedge clk);
    rst   = 1'bx;
    instr = 32'h403100B3;
    q_c.push_back(16'h1008);
    #1;
    e = q_c.pop_front();
    n_tests++;
    if (ctrl_c !== e) begin
      n_fail++;
      $display("FAIL reset_x_comb: got %h expected %h", ctrl_c, e);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_spec_vectors();
    logic [31:0] ins [10];
    logic [15:0] exp [10];
    logic [15:0] e;
    ins = '{32'h003100B3, 32'h403100B3, 32'h00012083, 32'h00112023, 32'h00000063,
            32'h000000EF, 32'h000010B7, 32'h40115093, 32'h00000073, 32'hFFFFFFFF};
    exp = '{16'h0008, 16'h1008, 16'h02AC, 16'h0290, 16'h0602,
            16'h0609, 16'h0A08, 16'h7208, 16'h0000, 16'h0000};
    for (int i = 0; i < 10; i++) begin
      drive(ins[i], 1'b0, exp[i]);
      #1;
      e = q_c.pop_front();
      n_tests++;
      if (ctrl_c !== e) begin
        n_fail++;
        $display("FAIL vec_comb_%0d instr=%h: got %h expected %h", i, ins[i], ctrl_c, e);
      end
      @(posedge clk);
      #1;
      e = q_r.pop_front();
      n_tests++;
      if (ctrl_r !== e) begin
        n_fail++;
        $display("FAIL vec_reg_%0d instr=%h: got %h expected %h", i, ins[i], ctrl_r, e);
      end
    end
  endtask

  task automatic test_sweep();
    logic [15:0] e;
    int          mism;
    mism = 0;
    for (int i = 0; i < NG; i++) begin
      drive(G_INS[i], 1'b0, G_EXP[i]);
      #1;
      e = q_c.pop_front();
      n_tests++;
      if (ctrl_c !== e) begin
        n_fail++;
        mism++;
        $display("FAIL sweep_comb_%0d instr=%h: got %h expected %h", i, G_INS[i], ctrl_c, e);
      end
      @(posedge clk);
      #1;
      e = q_r.pop_front();
      n_tests++;
      if (ctrl_r !== e) begin
        n_fail++;
        mism++;
        $display("FAIL sweep_reg_%0d instr=%h: got %h expected %h", i, G_INS[i], ctrl_r, e);
      end
    end
    $display("[TB] sweep of %0d encodings: %0d mismatches", NG, mism);
  endtask

  task automatic test_funct7_corners();
    logic [31:0] ins [5];
    logic [15:0] exp [5];
    logic [15:0] e;
    // ADDI/ORI/XOR with instr[30] set, OP with instr[1:0]!=11, SLLI-like SRAI neighbour.
    ins = '{32'hC0010093, 32'h40116093, 32'h403140B3, 32'h003100B1, 32'h40111093};
    exp = '{16'h0208,     16'h8208,     16'h5008,     16'h0000,     16'h2208};
    for (int i = 0; i < 5; i++) begin
      drive(ins[i], 1'b0, exp[i]);
      #1;
      e = q_c.pop_front();
      n_tests++;
      if (ctrl_c !== e) begin
        n_fail++;
        $display("FAIL f7_comb_%0d instr=%h: got %h expected %h", i, ins[i], ctrl_c, e);
      end
      @(posedge clk);
      #1;
      e = q_r.pop_front();
      n_tests++;
      if (ctrl_r !== e) begin
        n_fail++;
        $display("FAIL f7_reg_%0d instr=%h: got %h expected %h", i, ins[i], ctrl_r, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [5];
    logic        rs  [5];
    logic [15:0] exp [5];
    logic [15:0] e;
    ins = '{32'h003100B3, 32'h403100B3, 32'h00012083, 32'h00112023, 32'h000000EF};
    rs  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp = '{16'h0008, 16'h1008, 16'h02AC, 16'h0290, 16'h0609};
    for (int i = 0; i < 5; i++) begin
      drive(ins[i], rs[i], exp[i]);
      #1;
      e = q_c.pop_front();
      n_tests++;
      if (ctrl_c !== e) begin
        n_fail++;
        $display("FAIL b2b_comb_%0d: got %h expected %h", i, ctrl_c, e);
      end
      @(posedge clk);
      #1;
      e = q_r.pop_front();
      n_tests++;
      if (ctrl_r !== e) begin
        n_fail++;
        $display("FAIL b2b_reg_%0d: got %h expected %h", i, ctrl_r, e);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    instr   = 32'h00000000;
    test_reset();
    test_spec_vectors();
    test_sweep();
    test_funct7_corners();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
